instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 16 +
 rtl/word_assembler.sv | 31 +++
 rtl/instr_mem_loader.sv | 104 ++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package instr_mem_loader_pkg;
  localparam int DEPTH     = 64;
  localparam int ADDR_W    = 6;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int WORD_W    = LANE_W * NUM_LANES;
  localparam int IDX_W     = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; byte k lands in lane k.
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [LANE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);
  logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
  logic [IDX_W-1:0]                 byte_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      byte_idx        <= byte_idx + IDX_W'(1);
      lanes[byte_idx] <= byte_data;
    end
  end

  // Pulses with the accept of the top lane so the FSM can enter WRITE next cycle.
  assign word_full = accept && (byte_idx == IDX_W'(NUM_LANES - 1));
  assign word      = lanes;
endmodule

// File: rtl/instr_mem_loader.sv
// Streams bytes into instruction memory word by word while holding the CPU in reset.
module instr_mem_loader #(
  parameter int DEPTH  = instr_mem_loader_pkg::DEPTH,
  parameter int ADDR_W = instr_mem_loader_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import instr_mem_loader_pkg::state_t;
  import instr_mem_loader_pkg::IDLE;
  import instr_mem_loader_pkg::RECV;
  import instr_mem_loader_pkg::WRITE;
  import instr_mem_loader_pkg::DONE;

  localparam int CW = ADDR_W + 1;

  state_t            state, state_nx;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] word_idx;
  logic              idle_like, legal, take, accept, word_full, last_word;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign legal     = (word_count != '0) && (word_count <= CW'(DEPTH));
  assign take      = idle_like && start && legal;
  assign accept    = byte_ready && byte_valid;
  assign last_word = (CW'(word_idx) + CW'(1)) == count;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (take),
    .accept    (accept),
    .byte_data (byte_data),
    .word      (mem_wdata),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Every handshake/strobe output is a pure decode of state.
  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE: if (take) state_nx = RECV;
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_full) state_nx = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        busy     = 1'b1;
        state_nx = last_word ? DONE : RECV;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (take) state_nx = RECV;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      word_idx <= '0;
      err      <= 1'b0;
    end else begin
      if (idle_like && start) begin
        if (legal) begin
          count    <= word_count;
          word_idx <= '0;
          err      <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == WRITE && !last_word) word_idx <= word_idx + ADDR_W'(1);
    end
  end

  assign mem_addr = word_idx;
endmodule
